expr_eval: RTL and testbench
============================

// Module: expr_eval
// PURPOSE
//   Downstream evaluator for the ASCII expression stream that the syntax checker validates.
//   - Grammar: digit (op digit)* '=' with single-digit operands and op in {'+','*'}.
//   - '*' binds tighter than '+'.
//   - Consumes one character per strobed cycle. On '=' it emits the integer value and a syntax-error flag.
//   - Sits after the character source, beside the checker, and feeds the result display/compare logic.
// PARAMETERS
//   WIDTH  16  width of result and internal sum/term registers; all arithmetic is modulo 2**WIDTH
// PORTS
//   clk           in   1      single clock; all state updates on posedge clk
//   clr_n         in   1      asynchronous, active-low reset
//   in            in   8      ASCII character, sampled only when in_valid=1
//   in_valid      in   1      character strobe; no backpressure, a new char is allowed every cycle
//   result        out  WIDTH  value of the last terminated expression; held until the next '='
//   result_valid  out  1      one-cycle pulse, the cycle after '=' is sampled
//   err           out  1      qualifies result; 1 = syntax error, and result is then 0
//   busy          out  1      1 while an expression is open (state != IDLE)
//   ovf           out  1      sticky wrap flag, qualified by result_valid (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, clr_n=0): state=IDLE, sum=0, term=0, result=0, result_valid=0, err=0, ovf=0, busy=0.
//     - Reset mid-expression discards all partial state.
//   - Cycles with in_valid=0: no state change; result_valid drops to 0.
//   - State machine, advanced only on in_valid=1:
//     - IDLE: digit d -> NUM with sum=0, term=d. '=' -> emit err=1. Any other char -> ERR.
//     - NUM: '+' -> ADD. '*' -> MUL. '=' -> emit result=sum+term, err=0. Other -> ERR.
//     - ADD: digit d -> NUM with sum=sum+term, term=d. '=' -> emit err=1. Other -> ERR.
//     - MUL: digit d -> NUM with term=term*d. '=' -> emit err=1. Other -> ERR.
//     - ERR: every char except '=' is ignored. '=' -> emit err=1.
//   - "emit":
//     - At the sampling edge: result, err and ovf are registered; result_valid=1 for exactly the next cycle.
//     - State -> IDLE, sum=0, term=0.
//     - On any emit with err=1, result=0.
//   - Latency: '=' sampled at edge k -> result_valid high from edge k until edge k+1.
//   - Back-to-back: a digit at edge k+1 starts a new expression while result_valid is still high.
//   - Arithmetic:
//     - d = in-"0", zero-extended to WIDTH.
//     - Products and sums are truncated to WIDTH bits at every step.
//     - The final sum+term is also truncated.
//   - busy=1 in NUM/ADD/MUL/ERR, 0 in IDLE. It is registered, so it follows the state after each edge.
//   - Digits are "0".."9" only, i.e. 8'h30..8'h39. Space, '-', lowercase etc. are errors.
// CONFIGURATION
//   EXPR_EVAL_OVF_EN defined:
//     - An internal sticky bit sets when any sum or product step exceeds 2**WIDTH-1 (full-width carry or upper product bits != 0).
//     - It clears at emit and at reset.
//     - ovf is registered at emit alongside result.
//     - ovf=0 whenever err=1.
//   EXPR_EVAL_OVF_EN undefined:
//     - No overflow logic is built and ovf is tied to 0.
//     - Result wrap behaviour is identical.
// TESTING
//   1. "3+4*5=" (WIDTH=16), one char per cycle -> result_valid pulse 1 cycle after '=', result=23, err=0.
//   2. "9*9*9*9*9=" -> result=59049, err=0. Then "1=" sent immediately -> result=1 on the next pulse.
//   3. WIDTH=8, "9*9*9+1=" -> result=218 (729 mod 256 + 1).
//      - ovf=1 with EXPR_EVAL_OVF_EN defined, ovf=0 without.
//   4. "3++4=" -> err=1, result=0. "=" alone -> err=1. "7*=" -> err=1. Then "2*3=" -> result=6, err=0.
//   5. Chars "5","+" with in_valid gaps of 0-3 idle cycles, then "6=" -> result=11.
//      - The pulse is exactly 1 cycle wide; busy=1 from after '5' until the '=' edge.
//   6. "8*" then clr_n low for half a cycle (async, between edges), release, then "2=" -> result=2, err=0.
//      - All outputs read 0 while clr_n is low.

Source files
------------

// File: rtl/expr_eval_if.sv
// Character-in / result-out bundle for the expression evaluator.
// The evaluator takes the slave side; the character source takes the master side.
interface expr_eval_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       in;
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             err;
  logic             busy;
  logic             ovf;

  modport master (
    output in, in_valid,
    input  result, result_valid, err, busy, ovf
  );

  modport slave (
    input  in, in_valid,
    output result, result_valid, err, busy, ovf
  );
endinterface

// File: rtl/expr_eval.sv
// Streaming evaluator for "digit (op digit)* =" with '*' binding tighter than '+'.
// Define EXPR_EVAL_OVF_EN to build the sticky wrap detector that drives ovf.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        clr_n,
  expr_eval_if.slave  bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] NUM  = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] MUL  = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             is_digit, is_eq, is_plus, is_star;
  logic [WIDTH-1:0] digit;
  logic             emit, emit_err;

  // For '0'..'9' the low nibble is already the operand value.
  assign is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_eq    = (bus.in == 8'h3d);
  assign is_plus  = (bus.in == 8'h2b);
  assign is_star  = (bus.in == 8'h2a);
  assign digit    = WIDTH'(bus.in[3:0]);

  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    term_d         = term_q;
    result_d       = result_q;
    err_d          = err_q;
    result_valid_d = 1'b0;
    emit           = 1'b0;
    emit_err       = 1'b1;
    if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (is_digit) begin
            state_d = NUM;
            sum_d   = '0;
            term_d  = digit;
          end else if (is_eq) emit = 1'b1;
          else state_d = ERR;
        end
        NUM: begin
          if (is_plus)      state_d = ADD;
          else if (is_star) state_d = MUL;
          else if (is_eq) begin
            emit     = 1'b1;
            emit_err = 1'b0;
          end else state_d = ERR;
        end
        ADD: begin
          if (is_digit) begin
            state_d = NUM;
            sum_d   = sum_q + term_q;
            term_d  = digit;
          end else if (is_eq) emit = 1'b1;
          else state_d = ERR;
        end
        MUL: begin
          if (is_digit) begin
            state_d = NUM;
            term_d  = term_q * digit;
          end else if (is_eq) emit = 1'b1;
          else state_d = ERR;
        end
        ERR: begin
          if (is_eq) emit = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    if (emit) begin
      state_d        = IDLE;
      sum_d          = '0;
      term_d         = '0;
      result_valid_d = 1'b1;
      err_d          = emit_err;
      result_d       = emit_err ? '0 : sum_q + term_q;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q        <= IDLE;
      sum_q          <= '0;
      term_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      term_q         <= term_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.err          = err_q;
  assign bus.busy         = busy_q;

`ifdef EXPR_EVAL_OVF_EN
  logic               sticky_q, sticky_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH:0]     add_wide;
  logic [2*WIDTH-1:0] mul_wide;
  logic               add_step, mul_step;

  // Wide copies of the datapath steps; anything above the result width is a wrap.
  assign add_wide = {1'b0, sum_q} + {1'b0, term_q};
  assign mul_wide = {{WIDTH{1'b0}}, term_q} * {{WIDTH{1'b0}}, digit};
  assign add_step = bus.in_valid && (state_q == ADD) && is_digit;
  assign mul_step = bus.in_valid && (state_q == MUL) && is_digit;

  always_comb begin
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    if (add_step && (add_wide > {1'b0, {WIDTH{1'b1}}}))
      sticky_d = 1'b1;
    if (mul_step && (mul_wide > {{WIDTH{1'b0}}, {WIDTH{1'b1}}}))
      sticky_d = 1'b1;
    if (emit) begin
      sticky_d = 1'b0;
      ovf_d    = !emit_err && (sticky_q || (add_wide > {1'b0, {WIDTH{1'b1}}}));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: a 16-bit and an 8-bit instance share clock and reset.
// Expected ovf follows EXPR_EVAL_OVF_EN.
module tb_expr_eval;
`ifdef EXPR_EVAL_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  typedef struct {
    logic [15:0] result;
    logic        err;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;

  always #5 clk = ~clk;

  expr_eval_if #(.WIDTH(16)) b16 ();
  expr_eval_if #(.WIDTH(8))  b8 ();

  expr_eval #(.WIDTH(16)) u_dut16 (.clk(clk), .clr_n(clr_n), .bus(b16));
  expr_eval #(.WIDTH(8))  u_dut8  (.clk(clk), .clr_n(clr_n), .bus(b8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (b16.result_valid === 1'b1) begin
      if (q16.size() == 0) check("dut16_spurious_pulse", 1, 0);
      else begin
        e16 = q16.pop_front();
        $display("txn dut16 result=%0d err=%0d ovf=%0d", b16.result, b16.err, b16.ovf);
        check("dut16_result", 32'(b16.result), 32'(e16.result));
        check("dut16_err", 32'(b16.err), 32'(e16.err));
        check("dut16_ovf", 32'(b16.ovf), 32'(e16.ovf));
      end
    end
    if (b8.result_valid === 1'b1) begin
      if (q8.size() == 0) check("dut8_spurious_pulse", 1, 0);
      else begin
        e8 = q8.pop_front();
        $display("txn dut8 result=%0d err=%0d ovf=%0d", b8.result, b8.err, b8.ovf);
        check("dut8_result", 32'(b8.result), 32'(e8.result));
        check("dut8_err", 32'(b8.err), 32'(e8.err));
        check("dut8_ovf", 32'(b8.ovf), 32'(e8.ovf));
      end
    end
  end

  // One character per call; after the sampling edge checks pulse timing and busy.
  task automatic send_char(input bit sel, input byte c);
    logic v, b;
    @(negedge clk);
    if (sel) begin b8.in = c; b8.in_valid = 1'b1; end
    else begin b16.in = c; b16.in_valid = 1'b1; end
    @(posedge clk);
    #1;
    v = sel ? b8.result_valid : b16.result_valid;
    b = sel ? b8.busy : b16.busy;
    b8.in_valid  = 1'b0;
    b16.in_valid = 1'b0;
    if (c == "=") begin
      check("pulse_after_eq", 32'(v), 1);
      check("busy_after_eq", 32'(b), 0);
    end else begin
      check("no_pulse_mid_expr", 32'(v), 0);
      check("busy_mid_expr", 32'(b), 1);
    end
  endtask

  task automatic idle_cycles(input bit sel, input int n, input logic exp_busy);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check("idle_busy", 32'(sel ? b8.busy : b16.busy), 32'(exp_busy));
      check("idle_no_pulse", 32'(sel ? b8.result_valid : b16.result_valid), 0);
    end
  endtask

  task automatic send_expr(input bit sel, input string s, input int max_gap,
                           input logic [15:0] r, input logic e, input logic o);
    exp_t x;
    x.result = r; x.err = e; x.ovf = o;
    if (sel) q8.push_back(x); else q16.push_back(x);
    for (int i = 0; i < s.len(); i++) begin
      send_char(sel, s[i]);
      if (max_gap > 0 && i < s.len() - 1)
        idle_cycles(sel, $urandom_range(0, max_gap), 1'b1);
    end
  endtask

  initial begin
    clr_n = 1'b0;
    b16.in = 8'h00; b16.in_valid = 1'b0;
    b8.in  = 8'h00; b8.in_valid  = 1'b0;
    #12;
    check("rst_result", 32'(b16.result), 0);
    check("rst_valid", 32'(b16.result_valid), 0);
    check("rst_err", 32'(b16.err), 0);
    check("rst_busy", 32'(b16.busy), 0);
    check("rst_ovf", 32'(b16.ovf), 0);
    check("rst_result8", 32'(b8.result), 0);
    #1 clr_n = 1'b1;

    send_expr(1'b0, "3+4*5=", 0, 16'd23, 1'b0, 1'b0);
    send_expr(1'b0, "9*9*9*9*9=", 0, 16'd59049, 1'b0, 1'b0);
    send_expr(1'b0, "1=", 0, 16'd1, 1'b0, 1'b0);
    send_expr(1'b1, "9*9*9+1=", 0, 16'd218, 1'b0, OVF);
    send_expr(1'b0, "9*9*9*9*9*9=", 0, 16'd7153, 1'b0, OVF);
    send_expr(1'b0, "9*9*9*9*9+9*9*9*9*9=", 0, 16'd52562, 1'b0, OVF);
    send_expr(1'b0, "9*9*9*9*9*9+=", 0, 16'd0, 1'b1, 1'b0);
    send_expr(1'b0, "0=", 0, 16'd0, 1'b0, 1'b0);
    send_expr(1'b0, "3++4=", 0, 16'd0, 1'b1, 1'b0);
    send_expr(1'b0, "=", 0, 16'd0, 1'b1, 1'b0);
    send_expr(1'b0, "7*=", 0, 16'd0, 1'b1, 1'b0);
    send_expr(1'b0, "2*3=", 0, 16'd6, 1'b0, 1'b0);
    send_expr(1'b0, "3 +4=", 0, 16'd0, 1'b1, 1'b0);
    send_expr(1'b0, "x9+9=", 0, 16'd0, 1'b1, 1'b0);
    send_expr(1'b0, "8+/=", 0, 16'd0, 1'b1, 1'b0);
    send_expr(1'b1, "2*3+4*5=", 0, 16'd26, 1'b0, 1'b0);
    send_expr(1'b0, "5+6=", 3, 16'd11, 1'b0, 1'b0);
    send_expr(1'b0, "5+6=", 3, 16'd11, 1'b0, 1'b0);
    idle_cycles(1'b0, 2, 1'b0);
    check("result_held", 32'(b16.result), 11);

    // Abandon "8*" with an asynchronous reset pulse between clock edges.
    send_char(1'b0, "8");
    send_char(1'b0, "*");
    clr_n = 1'b0;
    #2;
    check("async_rst_result", 32'(b16.result), 0);
    check("async_rst_busy", 32'(b16.busy), 0);
    check("async_rst_valid", 32'(b16.result_valid), 0);
    check("async_rst_err", 32'(b16.err), 0);
    check("async_rst_ovf", 32'(b16.ovf), 0);
    clr_n = 1'b1;
    send_expr(1'b0, "2=", 0, 16'd2, 1'b0, 1'b0);

    for (int k = 0; k < 10 && (q16.size() != 0 || q8.size() != 0); k++)
      @(posedge clk);
    #1;
    check("sb_drain16", 32'(q16.size()), 0);
    check("sb_drain8", 32'(q8.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
